// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: control codes, FSM encoding, default width.
package alu_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic [3:0] CTRL_AND  = 4'd0;
  localparam logic [3:0] CTRL_OR   = 4'd1;
  localparam logic [3:0] CTRL_ADD  = 4'd2;
  localparam logic [3:0] CTRL_MUL  = 4'd3;
  localparam logic [3:0] CTRL_SUB  = 4'd6;
  localparam logic [3:0] CTRL_SLT  = 4'd7;
  localparam logic [3:0] CTRL_BNE  = 4'd8;
  localparam logic [3:0] CTRL_SRA  = 4'd9;
  localparam logic [3:0] CTRL_SRAV = 4'd11;
  localparam logic [3:0] CTRL_SLTU = 4'd13;
  localparam logic [3:0] CTRL_LUI  = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_unit_if.sv
// Request/response bundle between the ALU controller side and alu_seq_unit.
interface alu_seq_unit_if #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
);
  logic             start_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [4:0]       shamt_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  modport master (
    output start_i, ctrl_i, src1_i, src2_i, shamt_i,
    input  result_o, zero_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, ctrl_i, src1_i, src2_i, shamt_i,
    output result_o, zero_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/alu_seq_unit_mul_iter.sv
// Iterative shift-add multiplier datapath (low WIDTH bits of the product).
// ALU_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module mul_iter #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH,
  parameter int unsigned ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_next_c,
  output logic             last_c
);
  localparam int unsigned CNT_W = $clog2(ITERS + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      count  <= '0;
    end else if (step) begin
      acc    <= acc_next_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CNT_W'(1);
    end
  end

  assign acc_next_c = mplier[0] ? acc + mcand : acc;

  // last_c flags that the step taken this cycle is the final one
`ifdef ALU_MUL_EARLY_EXIT_EN
  assign last_c = (count == CNT_W'(ITERS - 1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign last_c = (count == CNT_W'(ITERS - 1));
`endif

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/compare, iterative MUL, start/busy/done handshake.
// ALU_MUL_EARLY_EXIT_EN: MUL may finish before MUL_ITERS iterations (see mul_iter).
module alu_seq_unit import alu_pkg::*; #(
  parameter int unsigned WIDTH     = alu_pkg::WIDTH,
  parameter int unsigned MUL_ITERS = WIDTH
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_seq_unit_if.slave bus
);
  state_t           state, state_n;
  logic [WIDTH-1:0] result_q, result_n;
  logic             zero_q, zero_n;
  logic             err_q, err_n;
  logic             done_q, done_n;
  logic             busy_q, busy_n;
  logic             mul_load, mul_step;
  logic [WIDTH-1:0] acc_next;
  logic             mul_last;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero, alu_err;

  mul_iter #(.WIDTH(WIDTH), .ITERS(MUL_ITERS)) u_mul (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .load       (mul_load),
    .step       (mul_step),
    .a          (bus.src1_i),
    .b          (bus.src2_i),
    .acc_next_c (acc_next),
    .last_c     (mul_last)
  );

  // Single-cycle datapath; BNE reports inequality on zero so branch logic always tests zero
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (bus.ctrl_i)
      CTRL_AND:  alu_res = bus.src1_i & bus.src2_i;
      CTRL_OR:   alu_res = bus.src1_i | bus.src2_i;
      CTRL_ADD:  alu_res = bus.src1_i + bus.src2_i;
      CTRL_MUL:  alu_res = '0;
      CTRL_SUB:  alu_res = bus.src1_i - bus.src2_i;
      CTRL_SLT:  alu_res = WIDTH'($signed(bus.src1_i) < $signed(bus.src2_i));
      CTRL_BNE:  alu_res = bus.src1_i - bus.src2_i;
      CTRL_SRA:  alu_res = $signed(bus.src2_i) >>> bus.shamt_i;
      CTRL_SRAV: alu_res = $signed(bus.src2_i) >>> bus.src1_i[4:0];
      CTRL_SLTU: alu_res = WIDTH'(bus.src1_i < bus.src2_i);
      CTRL_LUI:  alu_res = bus.src2_i << 16;
      default:   alu_err = 1'b1;
    endcase
    alu_zero = (bus.ctrl_i == CTRL_BNE) ? (bus.src1_i != bus.src2_i) : (alu_res == '0);
  end

  // Next-state and next-output logic
  always_comb begin
    state_n  = state;
    result_n = result_q;
    zero_n   = zero_q;
    err_n    = err_q;
    done_n   = 1'b0;
    busy_n   = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start_i) begin
          if (bus.ctrl_i == CTRL_MUL) begin
`ifdef ALU_MUL_EARLY_EXIT_EN
            if (bus.src2_i == '0) begin
              state_n  = ST_DONE;
              result_n = '0;
              zero_n   = 1'b1;
              err_n    = 1'b0;
              done_n   = 1'b1;
            end else begin
              state_n  = ST_MUL;
              mul_load = 1'b1;
              busy_n   = 1'b1;
            end
`else
            state_n  = ST_MUL;
            mul_load = 1'b1;
            busy_n   = 1'b1;
`endif
          end else begin
            state_n  = ST_DONE;
            result_n = alu_res;
            zero_n   = alu_zero;
            err_n    = alu_err;
            done_n   = 1'b1;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          state_n  = ST_DONE;
          result_n = acc_next;
          zero_n   = (acc_next == '0);
          err_n    = 1'b0;
          done_n   = 1'b1;
        end else begin
          busy_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      result_q <= result_n;
      zero_q   <= zero_n;
      err_q    <= err_n;
      done_q   <= done_n;
      busy_q   <= busy_n;
    end
  end

  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;
  assign bus.err_o    = err_q;
  assign bus.done_o   = done_q;
  assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed cases plus random ops against a behavioural model.
`timescale 1ns/1ps
module tb_alu_seq_unit;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  alu_seq_unit_if #(.WIDTH(32)) bus ();

  alu_seq_unit dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: what each code means arithmetically
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
    exp_t        e;
    logic [63:0] wide;
    e.res = 32'd0;
    e.err = 1'b0;
    case (c)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  e.res = a + b;
      4'd3:  begin wide = {32'd0, a} * {32'd0, b}; e.res = wide[31:0]; end
      4'd6:  e.res = a - b;
      4'd7:  e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd8:  e.res = a - b;
      4'd9:  begin wide = {{32{b[31]}}, b} >> sh; e.res = wide[31:0]; end
      4'd11: begin wide = {{32{b[31]}}, b} >> a[4:0]; e.res = wide[31:0]; end
      4'd13: e.res = (a < b) ? 32'd1 : 32'd0;
      4'd14: e.res = b * 32'h0001_0000;
      default: e.err = 1'b1;
    endcase
    e.zero = (c == 4'd8) ? (a != b) : (e.res == 32'd0);
    return e;
  endfunction

  function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
    int n;
    if (c != 4'd3) return 1;
`ifdef ALU_MUL_EARLY_EXIT_EN
    n = 0;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n + 1;
`else
    n = 32;
    return n + 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one op, wait for done with a cycle bound, check everything against the model
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    exp_t e;
    int   lat, bsy, exp_lat;
    e       = model(c, a, b, sh);
    exp_lat = model_lat(c, b);
    bus.start_i = 1'b1;
    bus.ctrl_i  = c;
    bus.src1_i  = a;
    bus.src2_i  = b;
    bus.shamt_i = sh;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.ctrl_i  = 4'($urandom);
    bus.src1_i  = $urandom;
    bus.src2_i  = $urandom;
    bus.shamt_i = 5'($urandom);
    lat = 1;
    bsy = 0;
    while (!bus.done_o && lat < 200) begin
      if (bus.busy_o) bsy++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy_cycles"}, 64'(bsy), 64'(exp_lat - 1));
    check({tag, " result"}, 64'(bus.result_o), 64'(e.res));
    check({tag, " zero"}, 64'(bus.zero_o), 64'(e.zero));
    check({tag, " err"}, 64'(bus.err_o), 64'(e.err));
    @(posedge clk); #1;
    check({tag, " done_pulse_end"}, 64'(bus.done_o), 64'd0);
  endtask

  initial begin
    logic [3:0]  codes [16];
    logic [3:0]  c;
    logic [31:0] a, b, got;
    exp_t        e;
    int          n_done, got_lat;

    codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9,
              4'd11, 4'd13, 4'd14, 4'd4, 4'd5, 4'd10, 4'd12, 4'd15};
    bus.start_i = 1'b0;
    bus.ctrl_i  = 4'd0;
    bus.src1_i  = 32'd0;
    bus.src2_i  = 32'd0;
    bus.shamt_i = 5'd0;

    repeat (3) @(posedge clk);
    #1;
    check("reset result", 64'(bus.result_o), 64'd0);
    check("reset zero", 64'(bus.zero_o), 64'd0);
    check("reset busy", 64'(bus.busy_o), 64'd0);
    check("reset done", 64'(bus.done_o), 64'd0);
    check("reset err", 64'(bus.err_o), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("sub 5-7", 4'd6, 32'd5, 32'd7, 5'd0);
    run_op("slt -1<1", 4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0);
    run_op("sltu max<1", 4'd13, 32'hFFFF_FFFF, 32'd1, 5'd0);
    run_op("sra", 4'd9, 32'd0, 32'h8000_0000, 5'd4);
    run_op("lui", 4'd14, 32'd0, 32'h0000_1234, 5'd0);

    // Reset in the middle of a MUL: outputs clear at once and the MUL never completes
    bus.start_i = 1'b1;
    bus.ctrl_i  = 4'd3;
    bus.src1_i  = 32'd7;
    bus.src2_i  = 32'd9;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("midmul_rst result", 64'(bus.result_o), 64'd0);
    check("midmul_rst busy", 64'(bus.busy_o), 64'd0);
    check("midmul_rst done", 64'(bus.done_o), 64'd0);
    check("midmul_rst zero", 64'(bus.zero_o), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done_o) n_done++;
    end
    check("midmul_rst no_done", 64'(n_done), 64'd0);
    run_op("add after rst", 4'd2, 32'd1, 32'd2, 5'd0);

    run_op("mul ffff x 10001", 4'd3, 32'h0000_FFFF, 32'h0001_0001, 5'd0);
    run_op("mul 5x3", 4'd3, 32'd5, 32'd3, 5'd0);
    run_op("mul 5x0", 4'd3, 32'd5, 32'd0, 5'd0);
    run_op("bne eq", 4'd8, 32'd4, 32'd4, 5'd0);
    run_op("bne ne", 4'd8, 32'd4, 32'd5, 5'd0);
    run_op("code5", 4'd5, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
    run_op("srav", 4'd11, 32'd35, 32'h8765_4321, 5'd0);

    // Back-to-back ADD starts give back-to-back done pulses
    bus.start_i = 1'b1;
    bus.ctrl_i  = 4'd2;
    bus.src1_i  = 32'd1;
    bus.src2_i  = 32'd2;
    @(posedge clk); #1;
    check("b2b first done", 64'(bus.done_o), 64'd1);
    check("b2b first result", 64'(bus.result_o), 64'd3);
    bus.src1_i = 32'd10;
    bus.src2_i = 32'd20;
    @(posedge clk); #1;
    check("b2b second done", 64'(bus.done_o), 64'd1);
    check("b2b second result", 64'(bus.result_o), 64'd30);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    check("b2b done falls", 64'(bus.done_o), 64'd0);

    // An ADD start pulsed while MUL is busy must be ignored
    e = model(4'd3, 32'h0000_1234, 32'h0000_5678, 5'd0);
    bus.start_i = 1'b1;
    bus.ctrl_i  = 4'd3;
    bus.src1_i  = 32'h0000_1234;
    bus.src2_i  = 32'h0000_5678;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    n_done  = 0;
    got     = 32'd0;
    got_lat = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (bus.done_o) begin
        n_done++;
        got     = bus.result_o;
        got_lat = cyc;
      end
      bus.start_i = (cyc == 4);
      if (cyc == 4) begin
        bus.ctrl_i = 4'd2;
        bus.src1_i = 32'd100;
        bus.src2_i = 32'd200;
      end
      @(posedge clk); #1;
    end
    check("busy_ignore done_count", 64'(n_done), 64'd1);
    check("busy_ignore result", 64'(got), 64'(e.res));
    check("busy_ignore latency", 64'(got_lat), 64'(model_lat(4'd3, 32'h0000_5678)));

    // Random ops over every code, including unsupported ones
    for (int i = 0; i < 60; i++) begin
      c = codes[$urandom_range(0, 15)];
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      run_op($sformatf("rand%0d c%0d", i, c), c, a, b, 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Multi-cycle ALU directly downstream of the ALU controller; consumes the 4-bit ALU control code plus two 32-bit operands.
- Logic, arithmetic, shift and compare ops complete in 1 cycle. MUL runs an iterative shift-add multiply (low 32 bits).
- start/busy/done handshake lets the future multi-cycle CPU stall on MUL.

Parameters:
- WIDTH, 32, operand/result width.
- MUL_ITERS, 32, shift-add iterations for MUL; must equal WIDTH.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  launch operation; sampled only when busy_o=0.
- ctrl_i  input  4  ALU control code.
- src1_i  input  WIDTH  operand A (rs).
- src2_i  input  WIDTH  operand B (rt/imm).
- shamt_i  input  5  shift amount for SRA.
- result_o  output  WIDTH  registered result; held until next done.
- zero_o  output  1  registered; 1 when result_o==0, except BNE (see below).
- busy_o  output  1  1 while MUL iterates.
- done_o  output  1  one-cycle pulse when result_o/zero_o are updated.
- err_o  output  1  registered with done_o; 1 for unsupported ctrl code.

Behaviour:
- Reset (async, rst_i=0): state IDLE; result_o=0, zero_o=0, busy_o=0, done_o=0, err_o=0; multiply registers cleared. A reset mid-MUL aborts it and produces no done_o.
- Codes:
  - 0 AND, 1 OR, 2 ADD, 6 SUB (all wrap mod 2^32, no overflow flag).
  - 3 MUL: low 32 bits of the product.
  - 7 SLT (signed) and 13 SLTU (unsigned): result is 1 or 0.
  - 8 BNE: result = A−B, zero_o = (A!=B), so branch logic always tests zero_o.
  - 9 SRA: B>>>shamt_i. 11 SRAV: B>>>A[4:0].
  - 14 LUI: B<<16.
  - Other codes: result 0, zero_o=1, err_o=1.
- FSM states: IDLE, MUL, DONE.
  - IDLE/DONE + start_i, non-MUL code: result registered at that edge, go to DONE. done_o=1 for the next cycle, so latency is 1.
  - IDLE/DONE + start_i, ctrl_i=3: capture multiplicand=A, multiplier=B, acc=0, count=0; go to MUL with busy_o=1.
  - MUL, each cycle: if multiplier[0], acc+=multiplicand. Then multiplicand<<=1, multiplier>>=1, count++.
  - MUL exit: after MUL_ITERS iterations, go to DONE with result_o=acc. Latency from the start edge to done_o is MUL_ITERS+1 = 33 cycles.
  - DONE with no start_i: go to IDLE. done_o falls.
- busy_o=0 in IDLE and DONE, so back-to-back starts are legal. start_i and ctrl_i are ignored while busy_o=1.
- Operands are captured at the start edge; later input changes do not affect the op in flight.
- err_o and zero_o update only together with done_o.

Optional Feature:
- Macro ALU_MUL_EARLY_EXIT_EN.
- Defined: MUL leaves when the remaining multiplier is zero. A multiplier of 0 at start goes straight to DONE (latency 1). Otherwise iterations = index of B's highest set bit + 1, and latency = that count + 1.
- Undefined: MUL always runs MUL_ITERS iterations (fixed 33-cycle latency).
- Results are identical either way.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for the ALU control codes (AND=0, OR=1, ADD=2, MUL=3, SUB=6, SLT=7, BNE=8, SRA=9, SRAV=11, SLTU=13, LUI=14);
  - the FSM state encoding (IDLE, MUL, DONE);
  - WIDTH default.
- One sub-module, mul_iter: holds the multiplicand/multiplier/accumulator/count registers and the step logic, with load/step/finished handshake to the parent FSM.

Test Plan:
- Reset mid-MUL: start MUL 7×9, drop rst_i on cycle 10 → outputs zero immediately, no done_o. Release reset, start ADD 1+2 → result_o=3, done_o one cycle later.
- Single-cycle ops:
  - SUB 5−7 → result_o=0xFFFFFFFE, zero_o=0.
  - SLT −1<1 → 1. SLTU 0xFFFFFFFF<1 → 0.
  - SRA 0x80000000>>>4 → 0xF8000000. LUI B=0x1234 → 0x12340000.
  - Each asserts done_o exactly 1 cycle after start.
- MUL 0xFFFF×0x10001 → result_o=0xFFFFFFFF. busy_o high for 32 cycles, done_o on cycle 33 (macro undefined).
- Macro defined:
  - MUL 5×3 → result 15, done_o on cycle 3.
  - MUL 5×0 → result 0, zero_o=1, done_o on cycle 1.
- BNE A=B=4 → zero_o=0. BNE A=4, B=5 → zero_o=1. Code 5 → err_o=1, result_o=0.
- Back-to-back and busy handling:
  - ADD starts on consecutive cycles → consecutive done pulses.
  - start_i pulsed during MUL busy with ADD code → ignored; MUL result unchanged; only one done_o.
